// File: rtl/traffic_phase_sched.sv
// Two-approach (North/East) phase scheduler with a pedestrian walk phase.
// Moore lamp outputs; the phase counter and state are exported for observation.
module traffic_phase_sched #(
  parameter int CW        = 8,
  parameter int GREEN_MIN = 20,
  parameter int GREEN_MAX = 60,
  parameter int YELLOW    = 5,
  parameter int ALL_RED   = 2,
  parameter int WALK_T    = 10
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          CAR_N,
  input  logic          CAR_E,
  input  logic          PED_REQ,
  output logic          GN,
  output logic          YN,
  output logic          RN,
  output logic          GE,
  output logic          YE,
  output logic          RE,
  output logic          WALK,
  output logic [CW-1:0] count,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_NG  = 3'd0,
    S_NY  = 3'd1,
    S_ARN = 3'd2,
    S_EG  = 3'd3,
    S_EY  = 3'd4,
    S_ARE = 3'd5,
    S_WK  = 3'd6
  } st_e;

  localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] WALK_M1 = CW'(WALK_T - 1);

  st_e           state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ped_pend_q, ped_pend_d;
  logic          last_n_q, last_n_d;   // 1: North was the last green served

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= S_NG;
      count_q    <= '0;
      ped_pend_q <= 1'b0;
      last_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ped_pend_q <= ped_pend_d;
      last_n_q   <= last_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_n_d   = last_n_q;
    ped_pend_d = ped_pend_q;
    count_d    = count_q;

    // Green exits on gap-out (own approach empty) once min green is met,
    // or on max-out; only when someone else is waiting.
    case (state_q)
      S_NG: if (count_q >= GMIN_M1 && (CAR_E || ped_pend_q) &&
                (count_q == GMAX_M1 || !CAR_N)) state_d = S_NY;
      S_EG: if (count_q >= GMIN_M1 && (CAR_N || ped_pend_q) &&
                (count_q == GMAX_M1 || !CAR_E)) state_d = S_EY;
      S_NY: if (count_q == YEL_M1) state_d = S_ARN;
      S_EY: if (count_q == YEL_M1) state_d = S_ARE;
      S_ARN: if (count_q == AR_M1) begin
        state_d  = ped_pend_q ? S_WK : S_EG;
        last_n_d = 1'b1;
      end
      S_ARE: if (count_q == AR_M1) begin
        state_d  = ped_pend_q ? S_WK : S_NG;
        last_n_d = 1'b0;
      end
      S_WK: if (count_q == WALK_M1) state_d = last_n_q ? S_EG : S_NG;
      default: state_d = S_NG;
    endcase

    if (state_q != S_WK && PED_REQ) ped_pend_d = 1'b1;
    if (state_d == S_WK && state_q != S_WK) ped_pend_d = 1'b0;

    if (state_d != state_q)
      count_d = '0;
    else if ((state_q == S_NG || state_q == S_EG) && count_q == GMAX_M1)
      count_d = count_q;
    else
      count_d = count_q + 1'b1;
  end

  always_comb begin
    GN = 1'b0; YN = 1'b0; RN = 1'b0;
    GE = 1'b0; YE = 1'b0; RE = 1'b0;
    WALK = 1'b0;
    case (state_q)
      S_NG:  begin GN = 1'b1; RE = 1'b1; end
      S_NY:  begin YN = 1'b1; RE = 1'b1; end
      S_EG:  begin GE = 1'b1; RN = 1'b1; end
      S_EY:  begin YE = 1'b1; RN = 1'b1; end
      S_WK:  begin RN = 1'b1; RE = 1'b1; WALK = 1'b1; end
      default: begin RN = 1'b1; RE = 1'b1; end
    endcase
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: doc/traffic_phase_sched.md
Name: traffic_phase_sched

Overview:
Phase scheduler for a two-way (North/East) intersection. It decides when each approach gets green from vehicle-presence sensors and a pedestrian button, using min-green, max-green, yellow, all-red and walk timing. It drives the six lamp outputs plus a WALK lamp directly, and exports its phase counter and state for observation in the traffic benches. It shares the signalled junction between the two road requesters and the pedestrian requester.

Parameters:
CW, 8, width of count port and internal phase counter; every timing parameter must be ≤ 2^CW-1
GREEN_MIN, 20, minimum green duration in CLK cycles (≥1)
GREEN_MAX, 60, maximum green duration when opposing demand exists (≥GREEN_MIN)
YELLOW, 5, yellow duration in cycles (≥1)
ALL_RED, 2, all-red clearance duration in cycles (≥1)
WALK_T, 10, pedestrian walk duration in cycles (≥1)

Ports:
CLK  in  1  clock; all state changes on posedge
CLR  in  1  synchronous active-high reset
CAR_N  in  1  vehicle present on North approach (level)
CAR_E  in  1  vehicle present on East approach (level)
PED_REQ  in  1  pedestrian button; any high cycle latches a request
GN, YN, RN  out  1 each  North green/yellow/red lamps
GE, YE, RE  out  1 each  East green/yellow/red lamps
WALK  out  1  pedestrian walk lamp
count  out  CW  cycles spent in the current state, starting at 0
state  out  3  current state code

Behaviour:
- Reset (CLR=1 at posedge): state=NG, count=0, ped_pend=0, last=N. Next cycle outputs are GN=1, RE=1, all other lamps 0, WALK=0. CLR has priority over everything. Reset mid-phase returns to NG on that edge.
- State codes: NG=0, NY=1, ARN=2, EG=3, EY=4, ARE=5, WK=6. Code 7 is illegal and goes to NG with count=0 on the next edge.
- Moore outputs, decoded from the registered state only:
  - NG: GN, RE
  - NY: YN, RE
  - ARN/ARE/WK: RN, RE
  - EG: GE, RN
  - EY: YE, RN
  - WALK=1 only in WK.
- Exactly one lamp per approach is lit in every state. GN and GE are never both 1.
- Counter: count=0 on every state change. Otherwise it increments by 1 each cycle. In NG/EG it saturates at GREEN_MAX-1.
- NG exit:
  - Let "demand" = CAR_E | ped_pend.
  - NG→NY when count ≥ GREEN_MIN-1 AND demand AND (count == GREEN_MAX-1 OR CAR_N == 0).
  - This gives gap-out at min green when North is empty, and max-out at GREEN_MAX otherwise.
  - With no demand, stay in NG indefinitely, count held at GREEN_MAX-1.
- EG exit: symmetric, with CAR_N in place of CAR_E and CAR_E in place of CAR_N.
- NY→ARN and EY→ARE at count == YELLOW-1.
- ARN at count == ALL_RED-1: go to WK if ped_pend, else EG. Set last=N.
- ARE at count == ALL_RED-1: go to WK if ped_pend, else NG. Set last=E.
- WK at count == WALK_T-1: go to EG if last==N, else NG.
- ped_pend:
  - Set by PED_REQ=1 in any state except WK.
  - Cleared on the edge entering WK; clear wins over a simultaneous set.
  - PED_REQ during WK is ignored.
  - Multiple presses before service count as one request.
- Sensor inputs are sampled only at posedge and need no synchronisation. The bench drives them synchronously.
- Phase durations (cycles a state is held) are:
  - NG/EG: GREEN_MIN to GREEN_MAX, or unbounded with no demand.
  - NY/EY: YELLOW.
  - ARN/ARE: ALL_RED.
  - WK: WALK_T.

Test Plan:
- Reset: CLR=1 for one posedge, then 0 → state=0, count=0, GN=1, RE=1, all other lamps 0, WALK=0.
- Gap-out: CAR_N=0, CAR_E=1 from reset release (cycle 0) → NG cycles 0–19, NY 20–24, ARN 25–26, EG from cycle 27 (GE=1, RN=1).
- Max-out: CAR_N=CAR_E=1 constant → NG 60 cycles, NY 5, ARN 2, EG 60, EY 5, ARE 2, back to NG at cycle 134. count never exceeds 59.
- No demand: CAR_E=0, PED_REQ=0, CAR_N either value for 500 cycles → remains NG, count holds at 59. Then raising CAR_E with CAR_N=0 → NY on the next edge.
- Pedestrian: PED_REQ pulse at cycle 3 during NG, CAR_N=CAR_E=0 → NY at cycle 20, ARN 25–26, WK 27–36 (WALK=1, RN=RE=1), EG at 37, ped_pend=0. A PED_REQ pulse at cycle 30 has no effect.
- Reset mid-phase: assert CLR during EY at count=2 → the next edge gives state=NG, count=0, ped_pend=0, and the full sequence restarts.
